counter_job_issuer: RTL and testbench

//   Initiator side of the counter start/done protocol: queues count jobs from an upstream

---
 rtl/counter_job_issuer.sv | 166 ++++++++++++++++
 tb/tb_counter_job_issuer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_job_issuer.sv
// Job issuer for a start/done counter: queues count jobs and issues them one at a time.
// Optional watchdog on the WAIT state is enabled by defining COUNTER_JOB_TIMEOUT_EN.
module counter_job_issuer #(
  parameter int CNT_WIDTH      = 7,
  parameter int FIFO_DEPTH     = 4,
  parameter int FIFO_AW        = 2,
  parameter int DONE_CNT_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      job_valid_i,
  input  logic [CNT_WIDTH-1:0]      job_val_i,
  output logic                      job_ready_o,
  output logic                      start_o,
  output logic [CNT_WIDTH-1:0]      cnt_val_o,
  input  logic                      done_i,
  output logic                      busy_o,
  output logic [FIFO_AW:0]          fifo_cnt_o,
  output logic [DONE_CNT_WIDTH-1:0] jobs_done_o,
  output logic                      err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  localparam logic [FIFO_AW:0] FULL_CNT = FIFO_DEPTH[FIFO_AW:0];

  state_e                      state_q, state_d;
  logic [CNT_WIDTH-1:0]        mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]            cnt_q, cnt_d;
  logic                        start_q, start_d;
  logic [CNT_WIDTH-1:0]        cnt_val_q, cnt_val_d;
  logic [DONE_CNT_WIDTH-1:0]   jobs_q, jobs_d;
  logic                        push, pop;
  logic                        fifo_empty;
  logic [CNT_WIDTH-1:0]        head;

`ifdef COUNTER_JOB_TIMEOUT_EN
  localparam int               WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0]             wd_q, wd_d;
  logic                        err_q, err_d;
`else
  logic [31:0]                 timeout_cfg_unused;
  assign timeout_cfg_unused = 32'(TIMEOUT_CYCLES);
`endif

  // Ready depends only on the registered count, so a pop never frees a slot in the same cycle.
  assign job_ready_o = (cnt_q != FULL_CNT);
  assign push        = job_valid_i & job_ready_o;
  assign fifo_empty  = (cnt_q == '0);
  assign head        = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= job_val_i;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    cnt_val_d = '0;
    jobs_d    = jobs_q;
    pop       = 1'b0;
`ifdef COUNTER_JOB_TIMEOUT_EN
    wd_d      = wd_q;
    err_d     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          // A zero-length job completes immediately without bothering the counter.
          if (head != '0) begin
            state_d   = S_ISSUE;
            start_d   = 1'b1;
            cnt_val_d = head;
          end else begin
            jobs_d = jobs_q + 1'b1;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef COUNTER_JOB_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      S_WAIT: begin
        if (done_i) begin
          state_d = S_IDLE;
          jobs_d  = jobs_q + 1'b1;
        end
`ifdef COUNTER_JOB_TIMEOUT_EN
        else if (wd_q == WD_LIMIT) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push && pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      cnt_val_q <= '0;
      jobs_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      cnt_val_q <= cnt_val_d;
      jobs_q    <= jobs_d;
    end
  end

`ifdef COUNTER_JOB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign start_o     = start_q;
  assign cnt_val_o   = cnt_val_q;
  assign busy_o      = (state_q != S_IDLE);
  assign fifo_cnt_o  = cnt_q;
  assign jobs_done_o = jobs_q;

endmodule

// File: tb/tb_counter_job_issuer.sv
// Directed and randomized checks for counter_job_issuer against a queue-based job model.
// Define COUNTER_JOB_TIMEOUT_EN for both bench and RTL to exercise the watchdog.
module tb_counter_job_issuer;

  logic       clk;
  logic       rst;
  logic       job_valid_i;
  logic [6:0] job_val_i;
  logic       job_ready_o;
  logic       start_o;
  logic [6:0] cnt_val_o;
  logic       done_i;
  logic       busy_o;
  logic [2:0] fifo_cnt_o;
  logic [7:0] jobs_done_o;
  logic       err_o;

  int n_checks = 0;
  int n_errors = 0;
  int exp_jobs = 0;
  logic [6:0] exp_q[$];

  counter_job_issuer #(
    .CNT_WIDTH(7), .FIFO_DEPTH(4), .FIFO_AW(2), .DONE_CNT_WIDTH(8), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .rst(rst),
    .job_valid_i(job_valid_i), .job_val_i(job_val_i), .job_ready_o(job_ready_o),
    .start_o(start_o), .cnt_val_o(cnt_val_o), .done_i(done_i),
    .busy_o(busy_o), .fifo_cnt_o(fifo_cnt_o), .jobs_done_o(jobs_done_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Offer one job and hold it until accepted; returns on the negedge after the accepting edge.
  task automatic push_one(input logic [6:0] v);
    bit ok;
    ok = 0;
    job_valid_i = 1'b1;
    job_val_i   = v;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (job_ready_o) ok = 1;
      tick();
    end
    job_valid_i = 1'b0;
    chk("push_accepted", 32'(ok), 32'd1);
  endtask

  task automatic done_pulse();
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
  endtask

  // Counter responder plus optional random producer; checks start order against exp_q.
  task automatic service(input int n_rand, input int max_cycles);
    int   wait_cnt;
    logic prev_start;
    bit   settled;
    logic [6:0] v;
    logic [6:0] exp_v;
    wait_cnt   = 0;
    prev_start = 1'b0;
    settled    = 0;
    for (int cyc = 0; cyc < max_cycles && !settled; cyc++) begin
      if (start_o) begin
        chk("start_one_cycle", 32'(prev_start), 32'd0);
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 7'h7f;
        chk("start_value_order", 32'(cnt_val_o), 32'(exp_v));
        wait_cnt = $urandom_range(2, 6);
        done_i   = 1'($urandom_range(0, 1));
      end else begin
        chk("cnt_val_zero_without_start", 32'(cnt_val_o), 32'd0);
        if (wait_cnt == 1) begin
          done_i   = 1'b1;
          wait_cnt = 0;
        end else begin
          done_i = 1'b0;
          if (wait_cnt > 1) wait_cnt--;
        end
      end
      prev_start = start_o;
      if (cyc < n_rand && $urandom_range(0, 3) != 0) begin
        v = ($urandom_range(0, 4) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
        job_valid_i = 1'b1;
        job_val_i   = v;
        if (job_ready_o) begin
          if (v != 0) exp_q.push_back(v);
          exp_jobs++;
        end
      end else begin
        job_valid_i = 1'b0;
      end
      if (cyc >= n_rand && exp_q.size() == 0 && !busy_o && fifo_cnt_o == 0 && wait_cnt == 0)
        settled = 1;
      tick();
    end
    job_valid_i = 1'b0;
    done_i      = 1'b0;
    chk("service_settled", 32'(settled), 32'd1);
    chk("jobs_done_total", 32'(jobs_done_o), 32'(exp_jobs % 256));
    chk("fifo_drained", 32'(fifo_cnt_o), 32'd0);
    chk("idle_after_drain", 32'(busy_o), 32'd0);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; job_valid_i = 1'b0; job_val_i = '0; done_i = 1'b0;
    tick(); tick();
    chk("rst_start", 32'(start_o), 0);
    chk("rst_cnt_val", 32'(cnt_val_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_fifo_cnt", 32'(fifo_cnt_o), 0);
    chk("rst_jobs_done", 32'(jobs_done_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_ready", 32'(job_ready_o), 1);
    rst = 1'b0;
    tick();

    // Single job: latency and one-cycle start pulse
    job_valid_i = 1'b1; job_val_i = 7'd50;
    tick();
    job_valid_i = 1'b0;
    chk("single_queued", 32'(fifo_cnt_o), 1);
    chk("single_no_early_start", 32'(start_o), 0);
    tick();
    chk("single_start", 32'(start_o), 1);
    chk("single_cnt_val", 32'(cnt_val_o), 50);
    chk("single_busy_issue", 32'(busy_o), 1);
    tick();
    chk("single_start_drop", 32'(start_o), 0);
    chk("single_cnt_val_drop", 32'(cnt_val_o), 0);
    chk("single_busy_wait", 32'(busy_o), 1);
    done_pulse();
    chk("single_jobs_done", 32'(jobs_done_o), 1);
    chk("single_idle", 32'(busy_o), 0);

    // Spurious done in IDLE and in ISSUE
    done_i = 1'b1; tick(); tick(); done_i = 1'b0;
    chk("spurious_idle_jobs", 32'(jobs_done_o), 1);
    chk("spurious_idle_busy", 32'(busy_o), 0);
    push_one(7'd33);
    tick();
    chk("spurious_issue_start", 32'(start_o), 1);
    done_i = 1'b1; tick(); done_i = 1'b0;
    chk("spurious_issue_busy", 32'(busy_o), 1);
    chk("spurious_issue_jobs", 32'(jobs_done_o), 1);
    done_pulse();
    chk("spurious_real_done", 32'(jobs_done_o), 2);

    // Zero job then 7
    job_valid_i = 1'b1; job_val_i = 7'd0; tick();
    job_val_i = 7'd7; tick();
    job_valid_i = 1'b0;
    chk("zero_counted", 32'(jobs_done_o), 3);
    chk("zero_no_start", 32'(start_o), 0);
    chk("zero_fifo", 32'(fifo_cnt_o), 1);
    tick();
    chk("zero_next_start", 32'(start_o), 1);
    chk("zero_next_val", 32'(cnt_val_o), 7);
    tick();
    done_pulse();
    chk("zero_jobs_after", 32'(jobs_done_o), 4);

    // Queue fill, no same-cycle bypass, ordered drain
    push_one(7'd10);
    push_one(7'd20);
    chk("queue_first_start", 32'(start_o), 1);
    chk("queue_first_val", 32'(cnt_val_o), 10);
    push_one(7'd30); push_one(7'd40); push_one(7'd50);
    chk("queue_full_cnt", 32'(fifo_cnt_o), 4);
    chk("queue_full_ready", 32'(job_ready_o), 0);
    chk("queue_full_busy", 32'(busy_o), 1);
    done_pulse();
    chk("queue_still_full", 32'(job_ready_o), 0);
    job_valid_i = 1'b1; job_val_i = 7'd60;
    tick();
    chk("queue_no_bypass_cnt", 32'(fifo_cnt_o), 3);
    chk("queue_ready_after_pop", 32'(job_ready_o), 1);
    chk("queue_second_val", 32'(cnt_val_o), 20);
    tick();
    job_valid_i = 1'b0;
    chk("queue_sixth_accepted", 32'(fifo_cnt_o), 4);
    done_pulse();
    exp_q.delete();
    exp_q.push_back(7'd30); exp_q.push_back(7'd40);
    exp_q.push_back(7'd50); exp_q.push_back(7'd60);
    exp_jobs = 10;
    service(0, 300);

    // Reset in the middle of WAIT with 3 jobs queued
    push_one(7'd11); push_one(7'd22); push_one(7'd33); push_one(7'd44);
    chk("rstmid_queued", 32'(fifo_cnt_o), 3);
    chk("rstmid_busy", 32'(busy_o), 1);
    rst = 1'b1;
    #1;
    chk("rstmid_async_fifo", 32'(fifo_cnt_o), 0);
    tick();
    chk("rstmid_busy_after", 32'(busy_o), 0);
    chk("rstmid_fifo_after", 32'(fifo_cnt_o), 0);
    chk("rstmid_start", 32'(start_o), 0);
    chk("rstmid_jobs", 32'(jobs_done_o), 0);
    chk("rstmid_ready", 32'(job_ready_o), 1);
    rst = 1'b0;
    tick();

    // Randomized traffic against the job model
    exp_q.delete();
    exp_jobs = 0;
    service(600, 4000);

    // Watchdog behaviour
    push_one(7'd9);
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      if (start_o) seen = 1; else tick();
    end
    chk("wd_start_seen", 32'(seen), 1);
`ifdef COUNTER_JOB_TIMEOUT_EN
    for (int k = 1; k <= 22; k++) begin
      tick();
      chk($sformatf("wd_err_k%0d", k), 32'(err_o), (k == 21) ? 32'd1 : 32'd0);
      chk($sformatf("wd_busy_k%0d", k), 32'(busy_o), (k <= 20) ? 32'd1 : 32'd0);
    end
    chk("wd_jobs_unchanged", 32'(jobs_done_o), 32'(exp_jobs % 256));
    chk("wd_fifo_empty", 32'(fifo_cnt_o), 0);
`else
    for (int k = 1; k <= 200; k++) begin
      tick();
      chk("nowd_busy", 32'(busy_o), 1);
      chk("nowd_err", 32'(err_o), 0);
    end
    chk("nowd_jobs_unchanged", 32'(jobs_done_o), 32'(exp_jobs % 256));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
